// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation solver slice.
// Holds the default RAM layout used by the interpolation engine and its
// loader, the default data/address widths and the loader FSM state type.
// No ports: this is a package imported by the loader.
package interp_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int ADDRESS_WIDTH = 13;
    localparam int VEC_LEN       = 2;

    // Default table layout: Z is the newest sample, N the previous one
    localparam int CURRENT_TIME_ADD = 0;
    localparam int TZ_ADD           = 1;
    localparam int TN_ADD           = 2;
    localparam int UN_ADD           = 3;
    localparam int UZ_ADD           = 5;
    localparam int UK_ADD           = 8;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_SHIFT_T,
        LD_SHIFT_U,
        LD_WR_T,
        LD_WAIT_U,
        LD_DONE
    } loader_state_e;

endpackage

// File: rtl/interp_table_loader.sv
// Writer side of the interpolation sample table.
// Takes a handshaked stream of frames (one time word followed by VEC_LEN
// state words) and writes them into the shared solver RAM. Before a new
// sample is written, the current newest sample (TZ/UZ) is copied into the
// previous-sample slots (TN/UN). Table_Valid is raised once two complete
// frames are present.
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   Sample_Valid/Ready/Is_Time/Data input word stream
//   Loader_Hold                    blocks the start of a new frame
//   Loader_RAM_RD_Address/Data     combinational read port of the RAM
//   Loader_RAM_WR_Enable/Address/Data write port of the RAM
//   Frame_Done                     one-cycle pulse after a frame completes
//   Table_Valid                    two consecutive frames loaded
//   Protocol_Error/_Clear          sticky error flag and its clear
module interp_table_loader #(
    parameter int ADDRESS_WIDTH = interp_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = interp_pkg::DATA_WIDTH,
    parameter int VEC_LEN       = interp_pkg::VEC_LEN,
    parameter int TZ_ADD        = interp_pkg::TZ_ADD,
    parameter int TN_ADD        = interp_pkg::TN_ADD,
    parameter int UN_ADD        = interp_pkg::UN_ADD,
    parameter int UZ_ADD        = interp_pkg::UZ_ADD
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Sample_Valid,
    output logic                     Sample_Ready,
    input  logic                     Sample_Is_Time,
    input  logic [DATA_WIDTH-1:0]    Sample_Data,
    input  logic                     Loader_Hold,
    output logic [ADDRESS_WIDTH-1:0] Loader_RAM_RD_Address,
    input  logic [DATA_WIDTH-1:0]    Loader_RAM_RD_Data,
    output logic                     Loader_RAM_WR_Enable,
    output logic [ADDRESS_WIDTH-1:0] Loader_RAM_WR_Address,
    output logic [DATA_WIDTH-1:0]    Loader_RAM_WR_Data,
    output logic                     Frame_Done,
    output logic                     Table_Valid,
    output logic                     Protocol_Error,
    input  logic                     Protocol_Error_Clear
);
    import interp_pkg::*;

    loader_state_e            state_q;
    logic [DATA_WIDTH-1:0]    newT_q;
    logic [7:0]               idx_q;
    logic [1:0]               framesLoaded_q;
    logic                     protocolError_q;
    logic                     protocolError_d;
    logic                     frameDone_q;

    logic                     accept;
    logic                     isLastWord;
    logic                     timeNotNewer;
    logic                     errorSet;
    logic [ADDRESS_WIDTH-1:0] idxAddr;

    // Ready is forced low while reset is held so an in-flight word is not
    // taken by a loader that is being cleared.
    assign Sample_Ready = !RST && (((state_q == LD_IDLE) && !Loader_Hold) ||
                                    (state_q == LD_WAIT_U));
    assign accept       = Sample_Valid && Sample_Ready;
    assign isLastWord   = (idx_q == 8'(VEC_LEN - 1));
    assign timeNotNewer = (newT_q <= Loader_RAM_RD_Data);
    assign idxAddr      = ADDRESS_WIDTH'(idx_q);

    assign Frame_Done     = frameDone_q;
    assign Table_Valid    = (framesLoaded_q == 2'd2);
    assign Protocol_Error = protocolError_q;

    // Error sources: stray state word while idle, a time that does not move
    // forward past the stored newest sample, and a time word mid-frame.
    always_comb begin
        errorSet = 1'b0;
        case (state_q)
            LD_IDLE:    errorSet = accept && !Sample_Is_Time;
            LD_SHIFT_T: errorSet = timeNotNewer;
            LD_WAIT_U:  errorSet = accept && Sample_Is_Time;
            default:    errorSet = 1'b0;
        endcase
        // A new error has priority over a clear in the same cycle
        protocolError_d = errorSet || (protocolError_q && !Protocol_Error_Clear);
    end

    // RAM ports are decoded straight from the state so each copy step reads
    // the Z slot and writes the matching N slot in the same cycle.
    always_comb begin
        Loader_RAM_RD_Address = '0;
        Loader_RAM_WR_Enable  = 1'b0;
        Loader_RAM_WR_Address = '0;
        Loader_RAM_WR_Data    = '0;
        case (state_q)
            LD_SHIFT_T: begin
                Loader_RAM_RD_Address = ADDRESS_WIDTH'(TZ_ADD);
                Loader_RAM_WR_Enable  = !timeNotNewer;
                Loader_RAM_WR_Address = ADDRESS_WIDTH'(TN_ADD);
                Loader_RAM_WR_Data    = Loader_RAM_RD_Data;
            end
            LD_SHIFT_U: begin
                Loader_RAM_RD_Address = ADDRESS_WIDTH'(UZ_ADD) + idxAddr;
                Loader_RAM_WR_Enable  = 1'b1;
                Loader_RAM_WR_Address = ADDRESS_WIDTH'(UN_ADD) + idxAddr;
                Loader_RAM_WR_Data    = Loader_RAM_RD_Data;
            end
            LD_WR_T: begin
                Loader_RAM_WR_Enable  = 1'b1;
                Loader_RAM_WR_Address = ADDRESS_WIDTH'(TZ_ADD);
                Loader_RAM_WR_Data    = newT_q;
            end
            LD_WAIT_U: begin
                Loader_RAM_WR_Enable  = accept && !Sample_Is_Time;
                Loader_RAM_WR_Address = ADDRESS_WIDTH'(UZ_ADD) + idxAddr;
                Loader_RAM_WR_Data    = Sample_Data;
            end
            default: begin
            end
        endcase
    end

    // Frame sequencing. The shift steps are skipped for the very first frame
    // (and after an abort) because there is no valid newest sample to age.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= LD_IDLE;
            newT_q          <= '0;
            idx_q           <= '0;
            framesLoaded_q  <= '0;
            protocolError_q <= 1'b0;
            frameDone_q     <= 1'b0;
        end else begin
            protocolError_q <= protocolError_d;
            frameDone_q     <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (accept && Sample_Is_Time) begin
                        newT_q  <= Sample_Data;
                        idx_q   <= '0;
                        state_q <= (framesLoaded_q != 2'd0) ? LD_SHIFT_T : LD_WR_T;
                    end
                end
                LD_SHIFT_T: begin
                    idx_q   <= '0;
                    state_q <= timeNotNewer ? LD_IDLE : LD_SHIFT_U;
                end
                LD_SHIFT_U: begin
                    if (isLastWord) begin
                        idx_q   <= '0;
                        state_q <= LD_WR_T;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                    end
                end
                LD_WR_T: begin
                    idx_q   <= '0;
                    state_q <= LD_WAIT_U;
                end
                LD_WAIT_U: begin
                    if (accept) begin
                        if (Sample_Is_Time) begin
                            framesLoaded_q <= '0;
                            newT_q         <= Sample_Data;
                            state_q        <= LD_WR_T;
                        end else if (isLastWord) begin
                            state_q <= LD_DONE;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                LD_DONE: begin
                    frameDone_q    <= 1'b1;
                    framesLoaded_q <= (framesLoaded_q == 2'd2) ? 2'd2 : framesLoaded_q + 2'd1;
                    state_q        <= LD_IDLE;
                end
                default: state_q <= LD_IDLE;
            endcase
        end
    end

endmodule
